// File: rtl/switch_debounce_toggle.sv
// Push-button synchronizer, debouncer and toggle switch.
// A debounced press inverts switch; sw_clear forces it low.
module switch_debounce_toggle #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  input  logic sw_clear,
  output logic switch,
  output logic stable,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    HELD_HIGH,
    WAIT_LOW
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             switch_q, switch_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      switch_q  <= 1'b0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= button;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      switch_q  <= switch_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD_HIGH;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = HELD_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_LOW;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
    // Clear has priority over a toggle landing on the same edge.
    stable_d = (state_d == HELD_HIGH) || (state_d == WAIT_LOW);
    if (sw_clear) begin
      switch_d = 1'b0;
    end else if (press_d) begin
      switch_d = ~switch_q;
    end else begin
      switch_d = switch_q;
    end
  end

  assign switch        = switch_q;
  assign stable        = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule
